id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register that builds the operand bundle for the EX-stage ALU
//  (rs_out, rt_out, imm_ext, ins, aluop, sll_slt, ALUSrc). It resolves RAW hazards
//  by forwarding from the EX, MEM and WB stages, stalls on load-use, and inserts
//  bubbles on stall or on a branch flush.
// PARAMETERS
//  DW  32  datapath width
//  AW   5  register address width; register 0 reads as zero and is never forwarded
// PORTS
//  clk           in   1   rising-edge clock
//  reset_n       in   1   asynchronous reset, active-low
//  id_valid      in   1   ID holds a real instruction
//  id_ins        in   DW  instruction word; rs=ins[25:21], rt=ins[20:16]
//  id_rs_data    in   DW  GRF read port 1
//  id_rt_data    in   DW  GRF read port 2
//  id_imm_ext    in   DW  extended immediate
//  id_aluop      in   3   ALU op (0 add,1 sub,2 and,3 or,4 not,5 sll)
//  id_sll_slt    in   1   ALU A-operand = rt
//  id_alusrc     in   1   ALU B-operand = imm
//  id_use_rs     in   1   instruction reads rs
//  id_use_rt     in   1   instruction reads rt
//  id_wa         in   AW  destination register
//  id_regwrite   in   1   writes the GRF
//  id_memread    in   1   instruction is a load
//  flush         in   1   branch/jump taken: discard ID instruction
//  ex_result     in   DW  ALU result of the instruction currently held here
//  mem_regwrite  in   1   MEM-stage writes the GRF
//  mem_memread   in   1   MEM-stage is a load
//  mem_wa        in   AW  MEM-stage destination register
//  mem_result    in   DW  MEM-stage ALU result
//  wb_regwrite   in   1   WB-stage writes the GRF
//  wb_wa         in   AW  WB-stage destination register
//  wb_wdata      in   DW  WB-stage write data
//  stall         out  1   hold PC and IF/ID (combinational)
//  rs_out,rt_out out  DW  registered forwarded operands to the ALU
//  imm_ext,ins   out  DW  registered
//  aluop         out  3   registered
//  sll_slt,alusrc out 1   registered
//  ex_valid,ex_regwrite,ex_memread out 1  registered
//  ex_wa         out  AW  registered
//  stall_cnt     out  16  saturating count of stall cycles
// BEHAVIOUR
//  - Reset (async, reset_n=0): every registered output and stall_cnt = 0, which
//    is a bubble. Reset asserted mid-stall clears the bubble state at once.
//  - Match(src,r): src_regwrite & src_wa==r & r!=0. EX-stage match also requires
//    ex_valid.
//  - Operand r (rs or rt) forwarding priority: EX match & ~ex_memread -> ex_result;
//    else MEM match & ~mem_memread -> mem_result; else WB match -> wb_wdata;
//    else GRF data. r==0 always yields 0.
//  - hazard = id_valid & [(id_use_rs & load-match(rs)) | (id_use_rt & load-match(rt))],
//    where load-match means an EX match with ex_memread, or a MEM match with
//    mem_memread.
//  - stall = hazard & ~flush. A load followed directly by a user gives 2 stall cycles
//    (load in EX, then in MEM); the user then gets the value from WB.
//  - Clock edge: if flush | stall | ~id_valid, load a bubble (ins=0, all control 0,
//    operands 0). Otherwise capture the ID bundle with forwarded operands.
//    Latency is 1 cycle.
//  - flush has priority over stall: the bubble is inserted and stall stays 0.
//  - stall_cnt increments on each cycle with stall=1 and saturates at 16'hFFFF.
// TESTING
//  1. Reset: reset_n=0 mid-run -> all outputs 0 immediately; stall=0.
//  2. add $3,$1,$2 then sub $4,$3,$1 (ex_result=0x15) -> next edge rs_out=0x15;
//     no stall.
//  3. $3 matches both MEM (mem_result=0xA) and WB (wb_wdata=0xB) -> rs_out=0xA
//     (priority).
//  4. lw $5 then or $6,$5,$5 -> stall=1 for 2 cycles, 2 bubbles; rs_out=rt_out=wb_wdata;
//     stall_cnt=2.
//  5. Writes to $0 with wb_wdata=0xFFFF -> rs_out=0, no stall.
//  6. Load-use hazard with flush=1 on the same cycle -> stall=0, bubble loaded,
//     stall_cnt unchanged.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bundle: ID-stage instruction fields, forwarding
// sources from EX/MEM/WB, and the registered EX-side operand outputs.
interface id_ex_operand_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  // ID-stage instruction bundle
  logic          id_valid;
  logic [DW-1:0] id_ins;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm_ext;
  logic [2:0]    id_aluop;
  logic          id_sll_slt;
  logic          id_alusrc;
  logic          id_use_rs;
  logic          id_use_rt;
  logic [AW-1:0] id_wa;
  logic          id_regwrite;
  logic          id_memread;
  logic          flush;

  // Forwarding sources
  logic [DW-1:0] ex_result;
  logic          mem_regwrite;
  logic          mem_memread;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_result;
  logic          wb_regwrite;
  logic [AW-1:0] wb_wa;
  logic [DW-1:0] wb_wdata;

  // Stage outputs
  logic          stall;
  logic [DW-1:0] rs_out;
  logic [DW-1:0] rt_out;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] ins;
  logic [2:0]    aluop;
  logic          sll_slt;
  logic          alusrc;
  logic          ex_valid;
  logic          ex_regwrite;
  logic          ex_memread;
  logic [AW-1:0] ex_wa;
  logic [15:0]   stall_cnt;

  modport master (
    output id_valid, id_ins, id_rs_data, id_rt_data, id_imm_ext, id_aluop,
           id_sll_slt, id_alusrc, id_use_rs, id_use_rt, id_wa, id_regwrite,
           id_memread, flush, ex_result, mem_regwrite, mem_memread, mem_wa,
           mem_result, wb_regwrite, wb_wa, wb_wdata,
    input  stall, rs_out, rt_out, imm_ext, ins, aluop, sll_slt, alusrc,
           ex_valid, ex_regwrite, ex_memread, ex_wa, stall_cnt
  );

  modport slave (
    input  id_valid, id_ins, id_rs_data, id_rt_data, id_imm_ext, id_aluop,
           id_sll_slt, id_alusrc, id_use_rs, id_use_rt, id_wa, id_regwrite,
           id_memread, flush, ex_result, mem_regwrite, mem_memread, mem_wa,
           mem_result, wb_regwrite, wb_wa, wb_wdata,
    output stall, rs_out, rt_out, imm_ext, ins, aluop, sll_slt, alusrc,
           ex_valid, ex_regwrite, ex_memread, ex_wa, stall_cnt
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: forwards EX/MEM/WB results into the ALU operands,
// stalls on load-use hazards and inserts bubbles on stall, flush or idle ID.
module id_ex_operand_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  id_ex_operand_stage_if.slave  bus
);

  logic [DW-1:0] rs_out_q, rt_out_q, imm_ext_q, ins_q;
  logic [2:0]    aluop_q;
  logic          sll_slt_q, alusrc_q;
  logic          ex_valid_q, ex_regwrite_q, ex_memread_q;
  logic [AW-1:0] ex_wa_q;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic [AW-1:0] rs_a, rt_a;
  logic          ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
  logic          ld_rs, ld_rt, stall_now, bubble;
  logic [DW-1:0] rs_fwd, rt_fwd;

  assign rs_a = bus.id_ins[21 +: AW];
  assign rt_a = bus.id_ins[16 +: AW];

  function automatic logic hit(input logic we, input logic [AW-1:0] wa,
                               input logic [AW-1:0] r);
    return we && (wa == r) && (r != '0);
  endfunction

  // Youngest non-load producer wins; register 0 is hard-wired to zero.
  function automatic logic [DW-1:0] pick(input logic [AW-1:0] r, input logic [DW-1:0] grf,
                                         input logic use_ex, input logic use_mem,
                                         input logic use_wb, input logic [DW-1:0] ex_v,
                                         input logic [DW-1:0] mem_v, input logic [DW-1:0] wb_v);
    if (r == '0)   return '0;
    if (use_ex)    return ex_v;
    if (use_mem)   return mem_v;
    if (use_wb)    return wb_v;
    return grf;
  endfunction

  // Source matching, operand forwarding and load-use hazard detection
  always_comb begin
    ex_hit_rs  = hit(ex_valid_q & ex_regwrite_q, ex_wa_q, rs_a);
    ex_hit_rt  = hit(ex_valid_q & ex_regwrite_q, ex_wa_q, rt_a);
    mem_hit_rs = hit(bus.mem_regwrite, bus.mem_wa, rs_a);
    mem_hit_rt = hit(bus.mem_regwrite, bus.mem_wa, rt_a);
    wb_hit_rs  = hit(bus.wb_regwrite, bus.wb_wa, rs_a);
    wb_hit_rt  = hit(bus.wb_regwrite, bus.wb_wa, rt_a);

    rs_fwd = pick(rs_a, bus.id_rs_data, ex_hit_rs & ~ex_memread_q,
                  mem_hit_rs & ~bus.mem_memread, wb_hit_rs,
                  bus.ex_result, bus.mem_result, bus.wb_wdata);
    rt_fwd = pick(rt_a, bus.id_rt_data, ex_hit_rt & ~ex_memread_q,
                  mem_hit_rt & ~bus.mem_memread, wb_hit_rt,
                  bus.ex_result, bus.mem_result, bus.wb_wdata);

    ld_rs = (ex_hit_rs & ex_memread_q) | (mem_hit_rs & bus.mem_memread);
    ld_rt = (ex_hit_rt & ex_memread_q) | (mem_hit_rt & bus.mem_memread);

    // A taken branch discards the consumer, so it never has to wait.
    stall_now = bus.id_valid & ((bus.id_use_rs & ld_rs) | (bus.id_use_rt & ld_rt))
                & ~bus.flush;
    bubble    = bus.flush | stall_now | ~bus.id_valid;

    stall_cnt_d = stall_cnt_q;
    if (stall_now && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Pipeline register: bubble or forwarded ID bundle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_out_q <= '0; rt_out_q <= '0; imm_ext_q <= '0; ins_q <= '0;
      aluop_q <= '0; sll_slt_q <= 1'b0; alusrc_q <= 1'b0;
      ex_valid_q <= 1'b0; ex_regwrite_q <= 1'b0; ex_memread_q <= 1'b0; ex_wa_q <= '0;
    end else if (bubble) begin
      rs_out_q <= '0; rt_out_q <= '0; imm_ext_q <= '0; ins_q <= '0;
      aluop_q <= '0; sll_slt_q <= 1'b0; alusrc_q <= 1'b0;
      ex_valid_q <= 1'b0; ex_regwrite_q <= 1'b0; ex_memread_q <= 1'b0; ex_wa_q <= '0;
    end else begin
      rs_out_q      <= rs_fwd;
      rt_out_q      <= rt_fwd;
      imm_ext_q     <= bus.id_imm_ext;
      ins_q         <= bus.id_ins;
      aluop_q       <= bus.id_aluop;
      sll_slt_q     <= bus.id_sll_slt;
      alusrc_q      <= bus.id_alusrc;
      ex_valid_q    <= 1'b1;
      ex_regwrite_q <= bus.id_regwrite;
      ex_memread_q  <= bus.id_memread;
      ex_wa_q       <= bus.id_wa;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall       = stall_now;
  assign bus.rs_out      = rs_out_q;
  assign bus.rt_out      = rt_out_q;
  assign bus.imm_ext     = imm_ext_q;
  assign bus.ins         = ins_q;
  assign bus.aluop       = aluop_q;
  assign bus.sll_slt     = sll_slt_q;
  assign bus.alusrc      = alusrc_q;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_regwrite = ex_regwrite_q;
  assign bus.ex_memread  = ex_memread_q;
  assign bus.ex_wa       = ex_wa_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: stimulus pushes model expectations,
// a monitor pops and compares the stall line and the registered bundle.
`timescale 1ns/1ps
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.DW(32), .AW(5)) bus ();

  id_ex_operand_stage #(.DW(32), .AW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] ins, rs, rt, imm;
    logic [2:0]  aluop;
    logic        sll, alusrc, valid, regwrite, memread;
    logic [4:0]  wa;
    logic [15:0] cnt;
  } exp_t;

  exp_t  bq[$];
  logic  sq[$];
  exp_t  m_ex, m_last;
  logic [15:0] m_cnt;
  logic  last_stall;
  logic  pipe_on;
  int    checks = 0;
  int    failures = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_op(input logic [4:0] r, input logic [31:0] grf);
    if (r == 5'd0) return 32'd0;
    if (m_ex.valid && m_ex.regwrite && m_ex.wa == r && !m_ex.memread) return bus.ex_result;
    if (bus.mem_regwrite && bus.mem_wa == r && !bus.mem_memread) return bus.mem_result;
    if (bus.wb_regwrite && bus.wb_wa == r) return bus.wb_wdata;
    return grf;
  endfunction

  function automatic logic load_pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (m_ex.valid && m_ex.regwrite && m_ex.memread && m_ex.wa == r) ||
           (bus.mem_regwrite && bus.mem_memread && bus.mem_wa == r);
  endfunction

  task automatic tick();
    @(negedge clk); #1;
    if (pipe_on) begin
      bus.wb_regwrite  = bus.mem_regwrite;
      bus.wb_wa        = bus.mem_wa;
      bus.wb_wdata     = bus.mem_result;
      bus.mem_regwrite = m_last.valid & m_last.regwrite;
      bus.mem_memread  = m_last.valid & m_last.memread;
      bus.mem_wa       = m_last.wa;
      bus.mem_result   = $urandom;
    end
  endtask

  task automatic commit();
    logic [4:0] rs, rt;
    logic st;
    exp_t n;
    #1;
    rs = bus.id_ins[25:21];
    rt = bus.id_ins[20:16];
    st = bus.id_valid && !bus.flush &&
         ((bus.id_use_rs && load_pending(rs)) || (bus.id_use_rt && load_pending(rt)));
    sq.push_back(st);
    n = '0;
    if (bus.id_valid && !bus.flush && !st) begin
      n.ins = bus.id_ins; n.rs = ref_op(rs, bus.id_rs_data); n.rt = ref_op(rt, bus.id_rt_data);
      n.imm = bus.id_imm_ext; n.aluop = bus.id_aluop; n.sll = bus.id_sll_slt;
      n.alusrc = bus.id_alusrc; n.valid = 1'b1; n.regwrite = bus.id_regwrite;
      n.memread = bus.id_memread; n.wa = bus.id_wa;
    end
    if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    n.cnt = m_cnt;
    m_last = m_ex;
    m_ex = n;
    last_stall = st;
    bq.push_back(n);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wa, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic urs, input logic urt, input logic we, input logic ld);
    bus.id_valid = v; bus.id_ins = {6'($urandom), rs, rt, wa, 11'($urandom)};
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm_ext = $urandom;
    bus.id_aluop = 3'($urandom_range(0, 5)); bus.id_sll_slt = 1'($urandom);
    bus.id_alusrc = 1'($urandom); bus.id_use_rs = urs; bus.id_use_rt = urt;
    bus.id_wa = wa; bus.id_regwrite = we; bus.id_memread = ld;
  endtask

  task automatic clear_fwd();
    bus.mem_regwrite = 1'b0; bus.mem_memread = 1'b0; bus.mem_wa = '0; bus.mem_result = '0;
    bus.wb_regwrite = 1'b0; bus.wb_wa = '0; bus.wb_wdata = '0;
  endtask

  task automatic model_reset();
    m_ex = '0; m_last = '0; m_cnt = '0; last_stall = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e, a;
    logic es;
    forever begin
      @(posedge clk or negedge clk or negedge reset_n);
      if (!reset_n) begin
        #1;
        a = {bus.ins, bus.rs_out, bus.rt_out, bus.imm_ext, bus.aluop, bus.sll_slt,
             bus.alusrc, bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_wa,
             bus.stall_cnt};
        checks++;
        if (a != '0 || bus.stall !== 1'b0) begin
          failures++;
          $display("FAIL reset: bundle=%h stall=%b required bundle=0 stall=0", a, bus.stall);
        end
      end else if (clk) begin
        #1;
        if (bq.size() > 0) begin
          e = bq.pop_front();
          a = {bus.ins, bus.rs_out, bus.rt_out, bus.imm_ext, bus.aluop, bus.sll_slt,
               bus.alusrc, bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_wa,
               bus.stall_cnt};
          checks++;
          if (a !== e) begin
            failures++;
            $display("FAIL bundle @%0t: got rs=%h rt=%h ins=%h v=%b cnt=%h full=%h required rs=%h rt=%h ins=%h v=%b cnt=%h full=%h",
                     $time, a.rs, a.rt, a.ins, a.valid, a.cnt, a, e.rs, e.rt, e.ins, e.valid, e.cnt, e);
          end
        end
      end else begin
        #3;
        if (sq.size() > 0) begin
          es = sq.pop_front();
          checks++;
          if (bus.stall !== es) begin
            failures++;
            $display("FAIL stall @%0t: got %b required %b", $time, bus.stall, es);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    pipe_on = 1'b0;
    model_reset();
    set_id(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b0; bus.ex_result = '0;
    clear_fwd();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // add $3,$1,$2 then sub $4,$3,$1 with EX result 0x15
    tick(); set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 1'b1, 1'b1, 1'b1, 1'b0); commit();
    tick(); set_id(1'b1, 5'd3, 5'd1, 5'd4, 32'h33, 32'h11, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.ex_result = 32'h15; commit();

    // $3 in both MEM and WB: MEM wins
    tick(); set_id(1'b1, 5'd3, 5'd3, 5'd7, 32'h99, 32'h99, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.mem_regwrite = 1'b1; bus.mem_wa = 5'd3; bus.mem_result = 32'hA;
    bus.wb_regwrite = 1'b1; bus.wb_wa = 5'd3; bus.wb_wdata = 32'hB; commit();

    // writes to $0 never forward; a load to $0 never stalls
    tick(); clear_fwd(); bus.wb_regwrite = 1'b1; bus.wb_wa = 5'd0; bus.wb_wdata = 32'hFFFF;
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h5678, 1'b1, 1'b1, 1'b1, 1'b1); commit();
    tick(); set_id(1'b1, 5'd0, 5'd0, 5'd9, 32'h1234, 32'h5678, 1'b1, 1'b1, 1'b1, 1'b0); commit();

    // lw $5 then or $6,$5,$5: two stalls, then WB value on both operands
    pipe_on = 1'b1;
    tick(); clear_fwd(); set_id(1'b1, 5'd1, 5'd0, 5'd5, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1); commit();
    for (int i = 0; i < 6; i++) begin
      tick(); set_id(1'b1, 5'd5, 5'd5, 5'd6, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0); commit();
      if (!last_stall) break;
    end
    pipe_on = 1'b0;

    // load-use hazard coinciding with a flush
    tick(); clear_fwd(); set_id(1'b1, 5'd2, 5'd0, 5'd7, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1); commit();
    tick(); set_id(1'b1, 5'd7, 5'd7, 5'd8, 32'h2, 32'h3, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.flush = 1'b1; commit();
    tick(); bus.flush = 1'b0; set_id(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0); commit();

    // reset asserted while a load-use stall is in progress
    tick(); set_id(1'b1, 5'd1, 5'd0, 5'd8, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1); commit();
    tick(); set_id(1'b1, 5'd8, 5'd8, 5'd9, 32'h4, 32'h5, 1'b1, 1'b1, 1'b1, 1'b0); commit();
    @(posedge clk); #2;
    clear_fwd(); reset_n = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // long stall against a MEM-stage load: counter must saturate
    tick(); bus.mem_regwrite = 1'b1; bus.mem_memread = 1'b1; bus.mem_wa = 5'd9;
    set_id(1'b1, 5'd9, 5'd0, 5'd10, 32'h7, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0); commit();
    for (int i = 0; i < 65540; i++) begin
      tick(); commit();
    end
    tick(); clear_fwd(); commit();

    // randomized traffic over a small register window to provoke matches
    for (int i = 0; i < 2000; i++) begin
      tick();
      set_id(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom_range(0, 3) == 0));
      bus.flush        = 1'($urandom_range(0, 7) == 0);
      bus.ex_result    = $urandom;
      bus.mem_regwrite = 1'($urandom);
      bus.mem_memread  = 1'($urandom_range(0, 3) == 0);
      bus.mem_wa       = 5'($urandom_range(0, 3));
      bus.mem_result   = $urandom;
      bus.wb_regwrite  = 1'($urandom);
      bus.wb_wa        = 5'($urandom_range(0, 3));
      bus.wb_wdata     = $urandom;
      commit();
    end

    @(posedge clk); #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
